// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types, defaults and helpers for the SDRAM burst scheduler
package sdram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int LEN_W_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } sched_state_t;

    // Index width for n items; never below one bit so single-channel builds keep legal ports.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_burst_sched_rr_arbiter.sv
// rtl/sdram_burst_sched_rr_arbiter.sv - round-robin index arbiter, search starts after the last grant
module rr_arbiter
    import sdram_pkg::*;
#(
    parameter int N = 2,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[(int'(ptr_q) + i) % N]) begin
                valid = 1'b1;
                grant = W'((int'(ptr_q) + i) % N);
            end
        end
    end

    // ptr holds the first channel to look at next time, i.e. last grant + 1.
    always_comb begin
        ptr_d = ptr_q;
        if (update && valid) begin
            ptr_d = W'((int'(grant) + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// rtl/sdram_burst_sched.sv - multi-channel SDRAM burst scheduler; SDRAM_PINGPONG_EN adds ping-pong regions
module sdram_burst_sched
    import sdram_pkg::*;
#(
    parameter int                CH_NUM    = 2,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                LEN_W     = LEN_W_DEF,
    parameter logic [ADDR_W-1:0] PP_OFFSET = ADDR_W'(24'h10_0000),
    localparam int               CH_W      = clog2(CH_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        ch_wr_rst,
    input  logic [CH_NUM-1:0]        ch_rd_rst,
    input  logic [CH_NUM*LEN_W-1:0]  wr_fifo_cnt,
    input  logic [CH_NUM*LEN_W-1:0]  rd_fifo_cnt,
    input  logic [CH_NUM-1:0]        rd_valid,
    input  logic [CH_NUM*ADDR_W-1:0] wr_beg_addr,
    input  logic [CH_NUM*ADDR_W-1:0] wr_end_addr,
    input  logic [CH_NUM*ADDR_W-1:0] rd_beg_addr,
    input  logic [CH_NUM*ADDR_W-1:0] rd_end_addr,
    input  logic [CH_NUM*LEN_W-1:0]  wr_burst_len,
    input  logic [CH_NUM*LEN_W-1:0]  rd_burst_len,
    input  logic                     sdram_wr_ack,
    input  logic                     sdram_rd_ack,
    output logic                     sdram_wr_req,
    output logic                     sdram_rd_req,
    output logic [ADDR_W-1:0]        sdram_wr_addr,
    output logic [ADDR_W-1:0]        sdram_rd_addr,
    output logic [CH_W-1:0]          grant_ch,
    output logic                     grant_wr,
    output logic                     grant_vld
);

    logic [LEN_W-1:0]  wr_len [CH_NUM];
    logic [LEN_W-1:0]  rd_len [CH_NUM];
    logic [LEN_W-1:0]  wr_cnt [CH_NUM];
    logic [LEN_W-1:0]  rd_cnt [CH_NUM];
    logic [ADDR_W-1:0] wr_beg [CH_NUM];
    logic [ADDR_W-1:0] wr_end [CH_NUM];
    logic [ADDR_W-1:0] rd_beg [CH_NUM];
    logic [ADDR_W-1:0] rd_end [CH_NUM];
    logic [CH_NUM-1:0] wr_elig;
    logic [CH_NUM-1:0] rd_elig;

    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            wr_len[k]  = wr_burst_len[k*LEN_W +: LEN_W];
            rd_len[k]  = rd_burst_len[k*LEN_W +: LEN_W];
            wr_cnt[k]  = wr_fifo_cnt[k*LEN_W +: LEN_W];
            rd_cnt[k]  = rd_fifo_cnt[k*LEN_W +: LEN_W];
            wr_beg[k]  = wr_beg_addr[k*ADDR_W +: ADDR_W];
            wr_end[k]  = wr_end_addr[k*ADDR_W +: ADDR_W];
            rd_beg[k]  = rd_beg_addr[k*ADDR_W +: ADDR_W];
            rd_end[k]  = rd_end_addr[k*ADDR_W +: ADDR_W];
            wr_elig[k] = (wr_len[k] != '0) && (wr_cnt[k] >= wr_len[k]);
            rd_elig[k] = (rd_len[k] != '0) && rd_valid[k] && (rd_cnt[k] < rd_len[k]);
        end
    end

    sched_state_t      state_q, state_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CH_W-1:0]   gch_q, gch_d;
    logic              gwr_q, gwr_d;
    logic              gvld_q, gvld_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              skip_q, skip_d;
    logic [ADDR_W-1:0] wr_next_q [CH_NUM];
    logic [ADDR_W-1:0] wr_next_d [CH_NUM];
    logic [ADDR_W-1:0] rd_next_q [CH_NUM];
    logic [ADDR_W-1:0] rd_next_d [CH_NUM];
    logic [CH_NUM-1:0] wr_rgn;
    logic [CH_NUM-1:0] rd_rgn;

`ifdef SDRAM_PINGPONG_EN
    logic [CH_NUM-1:0] wr_rgn_q, wr_rgn_d;
    logic [CH_NUM-1:0] rd_rgn_q, rd_rgn_d;
    assign wr_rgn = wr_rgn_q;
    assign rd_rgn = rd_rgn_q;
`else
    assign wr_rgn = '0;
    assign rd_rgn = '0;
`endif

    logic            wr_vld, rd_vld;
    logic [CH_W-1:0] wr_gnt, rd_gnt;
    logic            idle;

    assign idle = (state_q == ST_IDLE);

    rr_arbiter #(.N(CH_NUM)) u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (wr_elig),
        .update (idle),
        .grant  (wr_gnt),
        .valid  (wr_vld)
    );

    rr_arbiter #(.N(CH_NUM)) u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_elig),
        .update (idle && !wr_vld),
        .grant  (rd_gnt),
        .valid  (rd_vld)
    );

    logic              cur_ack;
    logic              cur_rst;
    logic [ADDR_W-1:0] cur_beg;
    logic [ADDR_W-1:0] cur_end;
    logic [ADDR_W:0]   len_ext;
    logic [ADDR_W:0]   nxt_sum;
    logic [ADDR_W:0]   last_sum;
    logic              wrap;
    logic [ADDR_W-1:0] next_val;

    // Post-burst address arithmetic, one bit wider so the end comparison cannot overflow.
    always_comb begin
        cur_ack  = gwr_q ? sdram_wr_ack : sdram_rd_ack;
        cur_rst  = gwr_q ? ch_wr_rst[gch_q] : ch_rd_rst[gch_q];
        cur_beg  = gwr_q ? wr_beg[gch_q] : rd_beg[gch_q];
        cur_end  = gwr_q ? wr_end[gch_q] : rd_end[gch_q];
        len_ext  = {{(ADDR_W + 1 - LEN_W){1'b0}}, len_q};
        nxt_sum  = {1'b0, start_q} + len_ext;
        last_sum = nxt_sum + len_ext - (ADDR_W + 1)'(1);
        wrap     = last_sum > {1'b0, cur_end};
        next_val = wrap ? cur_beg : nxt_sum[ADDR_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        gch_d     = gch_q;
        gwr_d     = gwr_q;
        gvld_d    = gvld_q;
        start_d   = start_q;
        len_d     = len_q;
        skip_d    = skip_q;
`ifdef SDRAM_PINGPONG_EN
        wr_rgn_d  = wr_rgn_q;
        rd_rgn_d  = rd_rgn_q;
`endif
        for (int k = 0; k < CH_NUM; k++) begin
            wr_next_d[k] = ch_wr_rst[k] ? wr_beg[k] : wr_next_q[k];
            rd_next_d[k] = ch_rd_rst[k] ? rd_beg[k] : rd_next_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_vld) begin
                    state_d   = ST_REQ;
                    gvld_d    = 1'b1;
                    gwr_d     = 1'b1;
                    gch_d     = wr_gnt;
                    wr_req_d  = 1'b1;
                    start_d   = wr_next_q[wr_gnt];
                    len_d     = wr_len[wr_gnt];
                    wr_addr_d = wr_next_q[wr_gnt] + (wr_rgn[wr_gnt] ? PP_OFFSET : '0);
                    skip_d    = ch_wr_rst[wr_gnt];
                end else if (rd_vld) begin
                    state_d   = ST_REQ;
                    gvld_d    = 1'b1;
                    gwr_d     = 1'b0;
                    gch_d     = rd_gnt;
                    rd_req_d  = 1'b1;
                    start_d   = rd_next_q[rd_gnt];
                    len_d     = rd_len[rd_gnt];
                    rd_addr_d = rd_next_q[rd_gnt] + (rd_rgn[rd_gnt] ? PP_OFFSET : '0);
                    skip_d    = ch_rd_rst[rd_gnt];
                end
            end
            ST_REQ: begin
                skip_d = skip_q | cur_rst;
                if (cur_ack) begin
                    state_d  = ST_XFER;
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                end
            end
            ST_XFER: begin
                skip_d = skip_q | cur_rst;
                if (!cur_ack) begin
                    state_d = ST_DONE;
                    gvld_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                // A channel reinit seen at any point of the burst wins over the advance.
                if (!(skip_q || cur_rst)) begin
                    if (gwr_q) begin
                        wr_next_d[gch_q] = next_val;
                    end else begin
                        rd_next_d[gch_q] = next_val;
                    end
`ifdef SDRAM_PINGPONG_EN
                    if (wrap && gwr_q) begin
                        wr_rgn_d[gch_q] = ~wr_rgn_q[gch_q];
                    end else if (wrap) begin
                        rd_rgn_d[gch_q] = ~wr_rgn_q[gch_q];
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            gch_q     <= '0;
            gwr_q     <= 1'b0;
            gvld_q    <= 1'b0;
            start_q   <= '0;
            len_q     <= '0;
            skip_q    <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) begin
                wr_next_q[k] <= wr_beg[k];
                rd_next_q[k] <= rd_beg[k];
            end
`ifdef SDRAM_PINGPONG_EN
            wr_rgn_q  <= '0;
            rd_rgn_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            gch_q     <= gch_d;
            gwr_q     <= gwr_d;
            gvld_q    <= gvld_d;
            start_q   <= start_d;
            len_q     <= len_d;
            skip_q    <= skip_d;
            wr_next_q <= wr_next_d;
            rd_next_q <= rd_next_d;
`ifdef SDRAM_PINGPONG_EN
            wr_rgn_q  <= wr_rgn_d;
            rd_rgn_q  <= rd_rgn_d;
`endif
        end
    end

    assign sdram_wr_req  = wr_req_q;
    assign sdram_rd_req  = rd_req_q;
    assign sdram_wr_addr = wr_addr_q;
    assign sdram_rd_addr = rd_addr_q;
    assign grant_ch      = gch_q;
    assign grant_wr      = gwr_q;
    assign grant_vld     = gvld_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb/tb_sdram_burst_sched.sv - randomized and directed bench for sdram_burst_sched (SDRAM_PINGPONG_EN aware)
module tb_sdram_burst_sched;

    localparam int CH   = 2;
    localparam int AW   = 24;
    localparam int LW   = 10;
    localparam int CW   = 1;
    localparam longint PP_OFF = 64'h10_0000;
`ifdef SDRAM_PINGPONG_EN
    localparam bit PP_ON = 1'b1;
`else
    localparam bit PP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH-1:0]    ch_wr_rst = '0;
    logic [CH-1:0]    ch_rd_rst = '0;
    logic [CH-1:0]    rd_valid  = '0;
    logic [LW-1:0]    wlen [CH];
    logic [LW-1:0]    rlen [CH];
    logic [LW-1:0]    wcnt [CH];
    logic [LW-1:0]    rcnt [CH];
    logic [AW-1:0]    wbeg [CH];
    logic [AW-1:0]    wend [CH];
    logic [AW-1:0]    rbeg [CH];
    logic [AW-1:0]    rend [CH];
    logic [CH*LW-1:0] wr_fifo_cnt, rd_fifo_cnt, wr_burst_len, rd_burst_len;
    logic [CH*AW-1:0] wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr;
    logic             sdram_wr_ack = 1'b0;
    logic             sdram_rd_ack = 1'b0;
    logic             sdram_wr_req, sdram_rd_req;
    logic [AW-1:0]    sdram_wr_addr, sdram_rd_addr;
    logic [CW-1:0]    grant_ch;
    logic             grant_wr, grant_vld;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            wr_fifo_cnt[k*LW +: LW]  = wcnt[k];
            rd_fifo_cnt[k*LW +: LW]  = rcnt[k];
            wr_burst_len[k*LW +: LW] = wlen[k];
            rd_burst_len[k*LW +: LW] = rlen[k];
            wr_beg_addr[k*AW +: AW]  = wbeg[k];
            wr_end_addr[k*AW +: AW]  = wend[k];
            rd_beg_addr[k*AW +: AW]  = rbeg[k];
            rd_end_addr[k*AW +: AW]  = rend[k];
        end
    end

    sdram_burst_sched #(.CH_NUM(CH), .ADDR_W(AW), .LEN_W(LW), .PP_OFFSET(24'h10_0000)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .ch_wr_rst     (ch_wr_rst),
        .ch_rd_rst     (ch_rd_rst),
        .wr_fifo_cnt   (wr_fifo_cnt),
        .rd_fifo_cnt   (rd_fifo_cnt),
        .rd_valid      (rd_valid),
        .wr_beg_addr   (wr_beg_addr),
        .wr_end_addr   (wr_end_addr),
        .rd_beg_addr   (rd_beg_addr),
        .rd_end_addr   (rd_end_addr),
        .wr_burst_len  (wr_burst_len),
        .rd_burst_len  (rd_burst_len),
        .sdram_wr_ack  (sdram_wr_ack),
        .sdram_rd_ack  (sdram_rd_ack),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_rd_req  (sdram_rd_req),
        .sdram_wr_addr (sdram_wr_addr),
        .sdram_rd_addr (sdram_rd_addr),
        .grant_ch      (grant_ch),
        .grant_wr      (grant_wr),
        .grant_vld     (grant_vld)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-channel next address, region bits and round-robin start points.
    longint m_wnext [CH];
    longint m_rnext [CH];
    bit     m_wrgn  [CH];
    bit     m_rrgn  [CH];
    int     m_wptr, m_rptr;

    task automatic clear_inputs();
        for (int k = 0; k < CH; k++) begin
            wlen[k] = '0; rlen[k] = '0; wcnt[k] = '0; rcnt[k] = '0;
            wbeg[k] = '0; wend[k] = 24'hff; rbeg[k] = '0; rend[k] = 24'hff;
        end
        rd_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ch_wr_rst = '0; ch_rd_rst = '0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < CH; k++) begin
            m_wnext[k] = longint'(wbeg[k]); m_rnext[k] = longint'(rbeg[k]);
            m_wrgn[k] = 1'b0; m_rrgn[k] = 1'b0;
        end
        m_wptr = 0; m_rptr = 0;
    endtask

    task automatic predict(output bit any, output bit is_wr, output int ch);
        any = 1'b0; is_wr = 1'b0; ch = 0;
        for (int i = 0; i < CH; i++) begin
            int k = (m_wptr + i) % CH;
            if (!any && wlen[k] != 0 && wcnt[k] >= wlen[k]) begin any = 1'b1; is_wr = 1'b1; ch = k; end
        end
        for (int i = 0; i < CH; i++) begin
            int k = (m_rptr + i) % CH;
            if (!any && rlen[k] != 0 && rd_valid[k] && rcnt[k] < rlen[k]) begin any = 1'b1; ch = k; end
        end
    endtask

    task automatic model_done(input bit is_wr, input int ch, input bit rst_mid);
        longint cur, len, lim, beg, nxt;
        bit wrapped;
        cur = is_wr ? m_wnext[ch] : m_rnext[ch];
        len = longint'(is_wr ? wlen[ch] : rlen[ch]);
        lim = longint'(is_wr ? wend[ch] : rend[ch]);
        beg = longint'(is_wr ? wbeg[ch] : rbeg[ch]);
        nxt = cur + len;
        wrapped = (nxt + len - 1) > lim;
        if (wrapped) nxt = beg;
        if (rst_mid) nxt = beg;
        if (is_wr) m_wnext[ch] = nxt; else m_rnext[ch] = nxt;
        if (PP_ON && wrapped && !rst_mid) begin
            if (is_wr) m_wrgn[ch] = !m_wrgn[ch];
            else       m_rrgn[ch] = !m_wrgn[ch];
        end
    endtask

    task automatic set_acks(input bit is_wr, input bit main_ack);
        if (is_wr) begin sdram_wr_ack = main_ack; sdram_rd_ack = 1'($urandom); end
        else       begin sdram_rd_ack = main_ack; sdram_wr_ack = 1'($urandom); end
    endtask

    // Runs one burst as the SDRAM controller would, checking the grant against the model.
    task automatic run_burst(input int ack_len, input bit rst_mid,
                             output bit got_wr, output int got_ch, output logic [AW-1:0] got_addr);
        bit any, is_wr, seen;
        int ch, dly;
        logic [AW-1:0] ea, obs;
        got_wr = 1'b0; got_ch = -1; got_addr = '0;
        predict(any, is_wr, ch);
        if (!any) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if ((sdram_wr_req | sdram_rd_req | grant_vld) !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_no_grant: got req=%b/%b vld=%b required 0", sdram_wr_req, sdram_rd_req, grant_vld);
                    break;
                end
            end
            return;
        end
        ea = AW'((is_wr ? m_wnext[ch] : m_rnext[ch]) + (((is_wr ? m_wrgn[ch] : m_rrgn[ch])) ? PP_OFF : 64'd0));
        if (is_wr) m_wptr = (ch + 1) % CH; else m_rptr = (ch + 1) % CH;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = sdram_wr_req | sdram_rd_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_timeout: got no request required a %s burst on ch %0d", is_wr ? "write" : "read", ch);
            return;
        end
        obs = is_wr ? sdram_wr_addr : sdram_rd_addr;
        got_wr = grant_wr; got_ch = int'(grant_ch); got_addr = obs;
        checks++;
        if ({grant_vld, grant_wr, int'(grant_ch), sdram_wr_req, sdram_rd_req} !== {1'b1, is_wr, ch, is_wr, !is_wr}) begin
            errors++;
            $display("FAIL grant: got vld=%b wr=%b ch=%0d req=%b/%b required vld=1 wr=%b ch=%0d", grant_vld, grant_wr, grant_ch,
                     sdram_wr_req, sdram_rd_req, is_wr, ch);
        end
        checks++;
        if (obs !== ea) begin
            errors++;
            $display("FAIL start_addr: got %h required %h", obs, ea);
        end
        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            set_acks(is_wr, 1'b0);
            @(negedge clk);
            checks++;
            if ((is_wr ? sdram_wr_req : sdram_rd_req) !== 1'b1) begin
                errors++;
                $display("FAIL req_hold: got req=0 required 1 while waiting for ack");
            end
        end
        for (int i = 1; i <= ack_len; i++) begin
            set_acks(is_wr, 1'b1);
            if (rst_mid && i == 2) begin
                if (is_wr) ch_wr_rst[ch] = 1'b1; else ch_rd_rst[ch] = 1'b1;
            end
            @(negedge clk);
            ch_wr_rst = '0; ch_rd_rst = '0;
            obs = is_wr ? sdram_wr_addr : sdram_rd_addr;
            checks++;
            if ({grant_vld, sdram_wr_req, sdram_rd_req, obs} !== {1'b1, 1'b0, 1'b0, got_addr}) begin
                errors++;
                $display("FAIL xfer: got vld=%b req=%b/%b addr=%h required vld=1 req=0/0 addr=%h", grant_vld, sdram_wr_req,
                         sdram_rd_req, obs, got_addr);
            end
        end
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({grant_vld, sdram_wr_req, sdram_rd_req} !== 3'b000) begin
            errors++;
            $display("FAIL done: got vld=%b req=%b/%b required all 0", grant_vld, sdram_wr_req, sdram_rd_req);
        end
        model_done(is_wr, ch, rst_mid);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr, grant_vld, grant_ch, grant_wr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b/%b addr=%h/%h vld=%b ch=%0d wr=%b required all 0", sdram_wr_req,
                     sdram_rd_req, sdram_wr_addr, sdram_rd_addr, grant_vld, grant_ch, grant_wr);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({sdram_wr_req, sdram_rd_req, grant_vld} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got req=%b/%b vld=%b required 0 with nothing eligible", sdram_wr_req, sdram_rd_req, grant_vld);
        end
    endtask

    task automatic test_seq_wrap();
        logic [AW-1:0] exp_a [5];
        bit w; int c; logic [AW-1:0] a;
        exp_a[0] = 24'd0; exp_a[1] = 24'd4; exp_a[2] = 24'd8; exp_a[3] = 24'd12; exp_a[4] = PP_ON ? 24'h10_0000 : 24'd0;
        clear_inputs();
        wlen[0] = 10'd4; wcnt[0] = 10'd4; wend[0] = 24'd15;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_burst(4, 1'b0, w, c, a);
            checks++;
            if (a !== exp_a[i] || c != 0 || !w) begin
                errors++;
                $display("FAIL seq_wrap[%0d]: got addr=%h ch=%0d wr=%b required addr=%h ch=0 wr=1", i, a, c, w, exp_a[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit w; int c; logic [AW-1:0] a;
        clear_inputs();
        wlen[0] = 10'd2; wcnt[0] = 10'd5; wlen[1] = 10'd3; wcnt[1] = 10'd3;
        wbeg[1] = 24'h1000; wend[1] = 24'h1fff;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_burst($urandom_range(1, 3), 1'b0, w, c, a);
            checks++;
            if (c != (i % 2)) begin
                errors++;
                $display("FAIL round_robin[%0d]: got ch=%0d required %0d", i, c, i % 2);
            end
        end
    endtask

    task automatic test_priority();
        bit w; int c; logic [AW-1:0] a;
        clear_inputs();
        wlen[0] = 10'd4; wcnt[0] = 10'd8;
        rlen[0] = 10'd4; rlen[1] = 10'd4; rbeg[1] = 24'h400; rend[1] = 24'h4ff;
        rd_valid = 2'b10;
        do_reset();
        run_burst(2, 1'b0, w, c, a);
        checks++;
        if (!w || c != 0) begin
            errors++;
            $display("FAIL prio_write_first: got wr=%b ch=%0d required wr=1 ch=0", w, c);
        end
        wcnt[0] = '0;
        for (int i = 0; i < 2; i++) begin
            run_burst(2, 1'b0, w, c, a);
            checks++;
            if (w || c != 1) begin
                errors++;
                $display("FAIL prio_read[%0d]: got wr=%b ch=%0d required wr=0 ch=1", i, w, c);
            end
        end
    endtask

    task automatic test_end_wrap();
        logic [AW-1:0] exp_a [3];
        bit w; int c; logic [AW-1:0] a;
        exp_a[0] = 24'd0; exp_a[1] = 24'd4; exp_a[2] = PP_ON ? 24'h10_0000 : 24'd0;
        clear_inputs();
        wlen[0] = 10'd4; wcnt[0] = 10'd4; wend[0] = 24'd9;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_burst(1, 1'b0, w, c, a);
            checks++;
            if (a !== exp_a[i]) begin
                errors++;
                $display("FAIL end9_wrap[%0d]: got %h required %h", i, a, exp_a[i]);
            end
        end
        clear_inputs();
        wlen[0] = 10'd4; wcnt[0] = 10'd4; wbeg[0] = 24'd0; wend[0] = 24'd2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_burst(2, 1'b0, w, c, a);
            checks++;
            if (a !== ((PP_ON && i == 1) ? 24'h10_0000 : 24'd0)) begin
                errors++;
                $display("FAIL short_region[%0d]: got %h required beg-based address", i, a);
            end
        end
    endtask

    task automatic test_chan_reset();
        bit w; int c; logic [AW-1:0] a;
        clear_inputs();
        wlen[1] = 10'd8; wcnt[1] = 10'd9; wbeg[1] = 24'h20; wend[1] = 24'hff;
        do_reset();
        run_burst(2, 1'b0, w, c, a);
        run_burst(3, 1'b1, w, c, a);
        checks++;
        if (a !== 24'h28) begin
            errors++;
            $display("FAIL chrst_burst: got %h required 000028", a);
        end
        run_burst(2, 1'b0, w, c, a);
        checks++;
        if (a !== 24'h20 || c != 1) begin
            errors++;
            $display("FAIL chrst_next: got addr=%h ch=%0d required 000020 ch=1", a, c);
        end
    endtask

    task automatic test_pingpong();
        logic [AW-1:0] exp_a [6];
        bit w; int c; logic [AW-1:0] a;
        exp_a[0] = 24'd0; exp_a[1] = 24'd4; exp_a[2] = PP_ON ? 24'h10_0000 : 24'd0;
        exp_a[3] = 24'd0; exp_a[4] = 24'd4; exp_a[5] = 24'd0;
        clear_inputs();
        wlen[0] = 10'd4; wcnt[0] = 10'd4; wend[0] = 24'd7;
        rlen[0] = 10'd4; rend[0] = 24'd7; rd_valid = 2'b01;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) wcnt[0] = '0;
            run_burst(2, 1'b0, w, c, a);
            checks++;
            if (a !== exp_a[i] || w !== (i < 3)) begin
                errors++;
                $display("FAIL pingpong[%0d]: got addr=%h wr=%b required addr=%h wr=%b", i, a, w, exp_a[i], i < 3);
            end
        end
    endtask

    task automatic test_random();
        bit w; int c, alen; logic [AW-1:0] a;
        clear_inputs();
        for (int k = 0; k < CH; k++) begin
            wbeg[k] = AW'(k * 'h400); wend[k] = AW'(k * 'h400 + 'h3f);
            rbeg[k] = AW'('h800 + k * 'h200); rend[k] = AW'('h800 + k * 'h200 + 'h2a);
        end
        do_reset();
        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < CH; k++) begin
                wlen[k] = LW'($urandom_range(0, 6)); wcnt[k] = LW'($urandom_range(0, 8));
                rlen[k] = LW'($urandom_range(0, 6)); rcnt[k] = LW'($urandom_range(0, 8));
            end
            rd_valid = CH'($urandom);
            alen = $urandom_range(1, 4);
            run_burst(alen, (alen >= 3) && ($urandom_range(0, 3) == 0), w, c, a);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required completion within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_seq_wrap();
        test_round_robin();
        test_priority();
        test_end_wrap();
        test_chan_reset();
        test_pingpong();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_sched.md
SDRAM_BURST_SCHED -- requirements
Module: sdram_burst_sched

Interface
REQ-001 SHALL have parameter CH_NUM, default 2: number of channels; each channel has one write stream and one read stream.
REQ-002 SHALL have parameter ADDR_W, default 24: SDRAM word-address width.
REQ-003 SHALL have parameter LEN_W, default 10: width of burst-length and FIFO-count fields.
REQ-004 SHALL have parameter PP_OFFSET, default 24'h10_0000: address offset of the second ping-pong region.
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: ch_wr_rst in CH_NUM, per-channel write-address reinit; ch_rd_rst in CH_NUM, per-channel read-address reinit.
REQ-007 SHALL have ports: wr_fifo_cnt in CH_NUM*LEN_W, write-FIFO fill; rd_fifo_cnt in CH_NUM*LEN_W, read-FIFO fill; rd_valid in CH_NUM, per-channel read enable.
REQ-008 SHALL have ports: wr_beg_addr, wr_end_addr, rd_beg_addr, rd_end_addr in CH_NUM*ADDR_W each; wr_burst_len, rd_burst_len in CH_NUM*LEN_W each; channel k occupies slice [k].
REQ-009 SHALL have ports: sdram_wr_ack in 1, sdram_rd_ack in 1, controller acks that stay high for one cycle per word.
REQ-010 SHALL have ports: sdram_wr_req out 1, sdram_rd_req out 1, sdram_wr_addr out ADDR_W, sdram_rd_addr out ADDR_W, all registered.
REQ-011 SHALL have ports: grant_ch out clog2(CH_NUM), channel owning the current burst; grant_wr out 1, 1 = write burst; grant_vld out 1, high from REQ through XFER; downstream uses them to mux FIFO enables.

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> XFER -> DONE -> IDLE.
REQ-013 SHALL consider write k eligible when wr_burst_len[k]!=0 and wr_fifo_cnt[k]>=wr_burst_len[k].
REQ-014 SHALL consider read k eligible when rd_burst_len[k]!=0, rd_valid[k]=1 and rd_fifo_cnt[k]<rd_burst_len[k].
REQ-015 SHALL, in IDLE, grant an eligible write before any eligible read, each class round-robin: the search starts at the channel after that class's last grant; REQ is entered on the next cycle.
REQ-016 SHALL hold sdram_*_req high in REQ until the matching ack is first seen high, then enter XFER with req low.
REQ-017 SHALL stay in XFER while the ack is high; ack low -> DONE.
REQ-018 SHALL present the burst start address on sdram_*_addr from REQ through XFER, stable; the unused direction's address output holds its last value.
REQ-019 SHALL, in DONE, set next = start+len; if next+len-1 > end then next = beg, otherwise next is kept; sums use ADDR_W+1 bits.
REQ-020 SHALL, when beg+len-1 > end, issue every burst at beg.
REQ-021 SHALL ignore acks of the direction not granted and all acks in IDLE and DONE.
REQ-022 SHALL apply ch_*_rst[k] by loading beg into channel k's address that cycle; if channel k is mid-burst, the burst completes but the DONE update is suppressed.
REQ-023 SHALL spend at least 4 cycles per burst (IDLE, REQ, XFER of 1+ cycles, DONE).

Reset
REQ-024 SHALL, on rst: FSM=IDLE; req outputs 0; addr outputs 0; grant_vld 0; grant_ch 0; grant_wr 0; RR pointers 0; per-channel addresses = beg values.
REQ-025 SHALL abandon any burst at rst with no address update.

Configuration
REQ-026 SHALL, with SDRAM_PINGPONG_EN defined, keep per channel a write-region bit and a read-region bit.
REQ-027 SHALL add PP_OFFSET to the address when the region bit is 1.
REQ-028 SHALL toggle the write-region bit on each write wrap and set the read-region bit to ~write-region bit on each read wrap.
REQ-029 SHALL reset both region bits to 0.
REQ-030 SHALL, without SDRAM_PINGPONG_EN, use a single region with no offset and no region registers.

Structure
REQ-031 SHALL place FSM state enum, ADDR_W/LEN_W defaults and helper clog2 in package sdram_pkg.
REQ-032 SHALL implement round-robin selection in sub-module rr_arbiter (parameter N; req vector, update strobe, grant index, valid), instantiated once per class.

Verification
REQ-033 SHALL verify: CH_NUM=1, len=4, wr_fifo_cnt=4, beg=0, end=15; ack 4 cycles per burst -> wr addrs 0,4,8,12,0.
REQ-034 SHALL verify: CH_NUM=2, both writes eligible continuously -> grant_ch alternates 0,1,0,1.
REQ-035 SHALL verify: write and read eligible together -> write granted first, read next; a read whose rd_valid=0 is never granted.
REQ-036 SHALL verify: beg=0, end=9, len=4 -> addrs 0,4,0 (8+3>9 wraps).
REQ-037 SHALL verify: ch_wr_rst mid-XFER -> burst completes, next addr = beg.
REQ-038 SHALL verify: SDRAM_PINGPONG_EN with PP_OFFSET=0x100000 -> after first write wrap, write addr 0x100000; read after its wrap uses region 0.
